// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: bus width, byte enables, FSM states.
// Also holds the address-legality check used on the access edge.
package data_mem_responder_pkg;

  localparam int DATA_BUS  = 32;
  localparam int MEM_LAT_W = 4;

  typedef logic [3:0] BYTE_EN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state;

  // Misaligned, or any set bit above the implemented word range.
  function automatic logic addr_bad(input logic [DATA_BUS-1:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/data_mem_responder_data_ram.sv
// Single-port 2**AW x 32 array, per-byte write enables, registered read (1 cycle).
// No backpressure: a strobe is honoured on the edge it is presented.
module data_ram
  import data_mem_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                clk,
  input  logic                wen,
  input  logic                ren,
  input  logic [AW-1:0]       idx,
  input  BYTE_EN              be,
  input  logic [DATA_BUS-1:0] wdata,
  output logic [DATA_BUS-1:0] rdata
);

  logic [DATA_BUS-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wen) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (ren) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, access LATENCY cycles after accept, response LATENCY+1 after.
// Response held stable under resp_ready=0; req_ready is low from accept until the response handshake.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_BUS-1:0] req_addr,
  input  logic [DATA_BUS-1:0] req_wdata,
  input  BYTE_EN              req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_BUS-1:0] resp_rdata,
  output logic                resp_err
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_RESP = RESP;

  localparam bit ZERO_LAT = (LATENCY == 0);
  localparam logic [MEM_LAT_W-1:0] CNT_INIT =
    (LATENCY == 0) ? '0 : MEM_LAT_W'(LATENCY - 1);

  logic [1:0]            state;
  logic [MEM_LAT_W-1:0]  cnt;
  logic                  lat_we;
  logic [DATA_BUS-1:0]   lat_addr;
  logic [DATA_BUS-1:0]   lat_wdata;
  BYTE_EN                lat_be;
  logic                  resp_load;
  logic                  resp_err_q;

  logic                  accept;
  logic                  acc_fire;
  logic                  acc_we;
  logic [DATA_BUS-1:0]   acc_addr;
  logic [DATA_BUS-1:0]   acc_wdata;
  BYTE_EN                acc_be;
  logic                  acc_err;
  logic [DATA_BUS-1:0]   ram_rdata;

  assign req_ready = rst && (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Zero-latency builds access straight from the request; otherwise from the latched copy.
  assign acc_we    = (state == S_IDLE) ? req_we    : lat_we;
  assign acc_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign acc_be    = (state == S_IDLE) ? req_be    : lat_be;
  assign acc_fire  = (state == S_IDLE) ? (accept && ZERO_LAT)
                                       : ((state == S_WAIT) && (cnt == '0));
  assign acc_err   = addr_bad(acc_addr, ADDR_WIDTH);

  data_ram #(
    .AW (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .wen   (acc_fire && acc_we && !acc_err),
    .ren   (acc_fire && !acc_we && !acc_err),
    .idx   (acc_addr[ADDR_WIDTH+1:2]),
    .be    (acc_be),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_load  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= CNT_INIT;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_load  <= 1'b0;
            resp_err_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (acc_fire) begin
        state      <= S_RESP;
        resp_load  <= !acc_we && !acc_err;
        resp_err_q <= acc_err;
      end
    end
  end

  // RAM read register only changes on a load access, so gating keeps rdata stable in RESP.
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_load ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against a word-array reference model.
// Instance 0 is the LATENCY=2 build, instance 1 the LATENCY=0 build.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       req_valid, req_ready, req_we;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0][3:0]  req_be;
  logic [1:0]       resp_valid, resp_ready, resp_err;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_responder #(
      .ADDR_WIDTH (10),
      .LATENCY    (g == 0 ? 2 : 0)
    ) dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_be     (req_be[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [31:0] model [2][1024];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction; bp cycles of resp_ready=0 with junk driven on req_* meanwhile.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input int bp, input string tag, output logic [31:0] rd);
    int w;
    int lat;
    logic e;
    logic [31:0] exp_rd, mask;
    e = exp_err(addr);
    exp_rd = (!we && !e) ? model[d][(addr / 4) % 1024] : 32'h0;
    w = 0;
    while (!req_ready[d] && w < 50) begin @(negedge clk); w++; end
    check({tag, "/ready"}, {31'b0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be; resp_ready[d] = (bp == 0);
    @(negedge clk);
    req_valid[d] = 1'b0; req_we[d] = $urandom; req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_be[d] = $urandom;
    lat = 1;
    while (!resp_valid[d] && lat < 50) begin @(negedge clk); lat++; end
    check({tag, "/lat"}, lat, lat_of(d) + 1);
    for (int i = 0; i < bp; i++) begin
      check({tag, "/bp_valid"}, {31'b0, resp_valid[d]}, 32'd1);
      check({tag, "/bp_rdata"}, resp_rdata[d], exp_rd);
      check({tag, "/bp_ready"}, {31'b0, req_ready[d]}, 32'd0);
      req_valid[d] = $urandom; req_we[d] = $urandom; req_addr[d] = $urandom_range(0, 255) * 4;
      req_wdata[d] = $urandom; req_be[d] = $urandom;
      @(negedge clk);
    end
    rd = resp_rdata[d];
    check({tag, "/rdata"}, resp_rdata[d], exp_rd);
    check({tag, "/err"}, {31'b0, resp_err[d]}, {31'b0, e});
    req_valid[d] = 1'b0;
    resp_ready[d] = 1'b1;
    @(negedge clk);
    check({tag, "/done"}, {30'b0, resp_valid[d], resp_err[d]}, 32'd0);
    if (we && !e) begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      model[d][addr / 4] = (model[d][addr / 4] & ~mask) | (wdata & mask);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] pool [8];
    logic [31:0] a;
    int w, acc, prev;

    rst = 2'b00; req_valid = '0; req_we = '0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 2'b11;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_outs", {resp_rdata[d][29:0], resp_valid[d], resp_err[d]}, 32'd0);
      check("reset_ready", {31'b0, req_ready[d]}, 32'd0);
    end
    rst = 2'b11;
    #1;
    check("release_ready0", {31'b0, req_ready[0]}, 32'd1);
    @(negedge clk);

    // Store then load
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "t1_st", rd);
    check("t1_st_rd", rd, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, "t1_ld", rd);
    check("t1_ld_rd", rd, 32'hDEADBEEF);

    // Byte enables
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, "t2_st1", rd);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, "t2_st2", rd);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "t2_ld", rd);
    check("t2_ld_rd", rd, 32'h11BB33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, "t2_be0", rd);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "t2_ld2", rd);
    check("t2_be0_rd", rd, 32'h11BB33DD);

    // Errors
    txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, "t3_init", rd);
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, "t3_mis", rd);
    txn(0, 1'b1, 32'h1000, 32'h99999999, 4'hF, 0, "t3_oor", rd);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, "t3_ld0", rd);
    check("t3_ld0_rd", rd, 32'h0BADF00D);

    // Backpressure with junk on the request side
    txn(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, "t4_st", rd);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 5, "t4_ld", rd);
    check("t4_ld_rd", rd, 32'hCAFEF00D);
    repeat (2) begin
      @(negedge clk);
      check("t4_no_second", {31'b0, resp_valid[0]}, 32'd0);
    end
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, "t4_reld", rd);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "t4_reld20", rd);

    // Zero-latency build: back-to-back loads
    for (int i = 0; i < 4; i++)
      txn(1, 1'b1, 32'h100 + 4 * i, $urandom, 4'hF, 0, "t5_st", rd);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; prev = -1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (!req_ready[1] && w < 10) begin @(negedge clk); w++; end
      check("t5_ready", {31'b0, req_ready[1]}, 32'd1);
      req_addr[1] = 32'h100 + 4 * (3 - i);
      acc = cyc;
      @(negedge clk);
      check("t5_valid", {31'b0, resp_valid[1]}, 32'd1);
      check("t5_rdata", resp_rdata[1], model[1][64 + 3 - i]);
      if (prev >= 0) check("t5_spacing", acc - prev, 32'd2);
      prev = acc;
    end
    req_valid[1] = 1'b0;
    @(negedge clk);

    // Reset while a store waits
    txn(0, 1'b1, 32'h30, 32'h12345678, 4'hF, 0, "t6_init", rd);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30;
    req_wdata[0] = 32'h55; req_be[0] = 4'hF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("t6_in_wait", {30'b0, req_ready[0], resp_valid[0]}, 32'd0);
    rst[0] = 1'b0;
    repeat (3) begin
      #1;
      check("t6_rst_valid", {31'b0, resp_valid[0]}, 32'd0);
      check("t6_rst_ready", {31'b0, req_ready[0]}, 32'd0);
      @(negedge clk);
    end
    rst[0] = 1'b1;
    #1;
    check("t6_release_ready", {31'b0, req_ready[0]}, 32'd1);
    @(negedge clk);
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, "t6_ld", rd);
    check("t6_ld_rd", rd, 32'h12345678);

    // Randomized traffic on both builds
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        pool[i] = 32'h200 + 4 * $urandom_range(0, 63) + 32'h100 * i;
        txn(d, 1'b1, pool[i], $urandom, 4'hF, 0, "rnd_fill", rd);
      end
      for (int i = 0; i < 40; i++) begin
        a = pool[$urandom_range(0, 7)];
        case ($urandom_range(0, 9))
          0: a = a + $urandom_range(1, 3);
          1: a = 32'h1000 + 4 * $urandom_range(0, 1023) + (32'h1 << $urandom_range(12, 31));
          default: ;
        endcase
        txn(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2), "rnd", rd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder serving the CPU's load/store port.
- Accepts one request at a time over a valid/ready channel and waits a programmable number of cycles.
- Then performs the word access with byte enables and returns data or an error on a valid/ready response channel.
- Sits beside the CPU top as the far end of its data-memory interface. Memory contents are internal.

Parameters:
ADDR_WIDTH, 10, word-address bits; storage is 2**ADDR_WIDTH 32-bit words (default 4 KiB).
LATENCY, 2, wait cycles between request accept and the access; legal range 0..15.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32 (DATA_BUS)  byte address.
req_wdata  input  32 (DATA_BUS)  store data, byte lanes aligned to the word.
req_be  input  4  byte enables for stores, bit i = byte lane i; ignored on loads.
resp_valid  output  1  response present.
resp_ready  input  1  requester accepts the response.
resp_rdata  output  32 (DATA_BUS)  load data; 0 for stores and errors.
resp_err  output  1  access rejected (misaligned or out of range).

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE, req_ready=0 while rst=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - Storage is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&&req_ready at a rising edge: latch we/addr/wdata/be.
  - If LATENCY>0, load counter=LATENCY-1 and go to WAIT.
  - If LATENCY=0, perform the access at the accept edge and go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - At the edge where the counter is 0, perform the access and go to RESP.
- Access rules:
  - Word index = addr[ADDR_WIDTH+1:2].
  - Error if addr[1:0]!=0 or addr[31:ADDR_WIDTH+2]!=0.
    - On error: no storage change, resp_err=1, resp_rdata=0.
  - Store: write only the lanes with be[i]=1. be=0 is a legal no-op, not an error. resp_rdata=0.
  - Load: resp_rdata = full stored word, sampled at the access edge.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until the handshake.
  - On resp_valid&&resp_ready, go to IDLE next cycle; resp_valid, resp_rdata and resp_err return to 0.
  - req_ready=0 during RESP, so no request is accepted in the same cycle as the response handshake.
- Latency:
  - resp_valid rises exactly LATENCY+1 cycles after the accept edge.
  - Minimum cycle time per transaction is LATENCY+2 with resp_ready held 1.
- Read-after-write: a load accepted after a store's response observes the stored data.
- Inputs are ignored outside the IDLE accept cycle; changes to req_* during WAIT/RESP have no effect.
- Backpressure: resp_ready=0 holds RESP indefinitely with no data change.
- Reset mid-operation: the in-flight request is discarded. A store still in WAIT must not commit. A store already committed stays committed.
- Reset release: req_ready rises in the first cycle with rst=1.

Decomposition:
- Add to types_pkg:
  - BYTE_EN typedef (logic [3:0]);
  - mem_state enum {IDLE, WAIT, RESP};
  - MEM_LAT_W constant = 4 (counter width).
- Reuse DATA_BUS for addr/wdata/rdata.
- One sub-module: data_ram.
  - Single-port synchronous array, 2**ADDR_WIDTH x 32, per-byte write enables, registered read.
  - The FSM drives its enables on the access edge.

Test Plan:
1. Store then load, LATENCY=2:
   - Stimulus: store addr 0x10, wdata 0xDEADBEEF, be 4'hF; then load 0x10.
   - Required: each resp_valid 3 cycles after its accept; store rdata=0, err=0; load rdata 0xDEADBEEF, err=0.
2. Byte enables:
   - Stimulus: store 0x11223344 to 0x20 with be F; then store 0xAABBCCDD with be 4'b0101; then load 0x20.
   - Required: load rdata 0x11BB33DD.
3. Errors:
   - Stimulus: load 0x22 (misaligned); store to 0x1000 (out of range for ADDR_WIDTH=10); then load 0x0.
   - Required: the two erroring accesses give err=1, rdata=0. The load of 0x0 returns its prior contents unchanged.
4. Backpressure and stability:
   - Stimulus: hold resp_ready=0 for 5 cycles during a load of a word holding 0xCAFEF00D; toggle req_* meanwhile.
   - Required: resp_valid stays 1, rdata stays 0xCAFEF00D, req_ready stays 0, no second accept.
5. LATENCY=0 build:
   - Stimulus: back-to-back loads with resp_ready=1.
   - Required: resp_valid 1 cycle after accept; accepts every 2 cycles.
6. Reset mid-WAIT:
   - Stimulus: store 0x55 to 0x30 and assert rst during WAIT; after release, load 0x30 (previously 0x12345678).
   - Required: resp_valid=0 during reset; load rdata 0x12345678 (store not committed).
